// File: rtl/tthbif_uart_rx_if.sv
// Received-byte handshake bundle: master drives data/valid, slave returns ready.
interface tthbif_uart_rx_if;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output data_o, output valid_o, input ready_i);
  modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/tthbif_uart_rx.sv
// UART receiver, 8N1 (8E1 when TTHBIF_UART_RX_PARITY_EN is defined); byte out 1 cycle after stop sample.
// Holds one byte until ready_i; a good frame arriving while full is dropped with an overrun pulse.
module tthbif_uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             uart_rx_i,
  tthbif_uart_rx_if.master rx_if,
  output logic             frm_err_o,
  output logic             overrun_o,
  output logic             par_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
`ifdef TTHBIF_UART_RX_PARITY_EN
    , S_PARITY
`endif
  } state_t;

  state_t        state_q;
  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic [7:0]    data_q;
  logic          valid_q;
  logic          stop_done_q;
  logic          stop_bit_q;
  logic          frm_err_q;
  logic          overrun_q;
  logic          rx_s;
  logic          par_ok;

  assign rx_s = sync_q[1];

`ifdef TTHBIF_UART_RX_PARITY_EN
  logic par_bit_q;
  logic par_err_q;
  assign par_ok    = ~(^{shift_q, par_bit_q});
  assign par_err_o = par_err_q;
`else
  assign par_ok    = 1'b1;
  assign par_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      sync_q      <= 2'b11;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      stop_done_q <= 1'b0;
      stop_bit_q  <= 1'b1;
      frm_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef TTHBIF_UART_RX_PARITY_EN
      par_bit_q   <= 1'b0;
      par_err_q   <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], uart_rx_i};
      frm_err_q <= 1'b0;
      overrun_q <= 1'b0;
`ifdef TTHBIF_UART_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
      if (valid_q && rx_if.ready_i) valid_q <= 1'b0;

      if (!en_i) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (!rx_s) begin
              state_q     <= S_START;
              cnt_q       <= '0;
              idx_q       <= '0;
              stop_done_q <= 1'b0;
            end
          end
          S_START: begin
            if (cnt_q == HALF_LAST) begin
              cnt_q   <= '0;
              state_q <= rx_s ? S_IDLE : S_DATA;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          S_DATA: begin
            if (cnt_q == LAST) begin
              cnt_q   <= '0;
              shift_q <= {rx_s, shift_q[7:1]};
              if (idx_q == 3'd7) begin
`ifdef TTHBIF_UART_RX_PARITY_EN
                state_q <= S_PARITY;
`else
                state_q <= S_STOP;
`endif
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`ifdef TTHBIF_UART_RX_PARITY_EN
          S_PARITY: begin
            if (cnt_q == LAST) begin
              cnt_q     <= '0;
              par_bit_q <= rx_s;
              state_q   <= S_STOP;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
`endif
          S_STOP: begin
            if (!stop_done_q) begin
              if (cnt_q == LAST) begin
                cnt_q       <= '0;
                stop_bit_q  <= rx_s;
                stop_done_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CW'(1);
              end
            end else begin
              // Frame verdict is taken one cycle after the stop sample.
              state_q     <= S_IDLE;
              stop_done_q <= 1'b0;
              frm_err_q   <= ~stop_bit_q;
`ifdef TTHBIF_UART_RX_PARITY_EN
              par_err_q   <= ~par_ok;
`endif
              if (stop_bit_q && par_ok) begin
                if (valid_q && !rx_if.ready_i) begin
                  overrun_q <= 1'b1;
                end else begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign rx_if.data_o  = data_q;
  assign rx_if.valid_o = valid_q;
  assign frm_err_o     = frm_err_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_tthbif_uart_rx.sv
// Scoreboard bench for tthbif_uart_rx at CLKS_PER_BIT=16; honours TTHBIF_UART_RX_PARITY_EN.
module tb_tthbif_uart_rx;
  localparam int C = 16;
`ifdef TTHBIF_UART_RX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int LAT = 3 + 9 * C + C / 2 + PB * C;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic rx  = 1'b1;
  logic frm, ovr, par;

  tthbif_uart_rx_if bus ();

  tthbif_uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .uart_rx_i (rx),
    .rx_if     (bus.master),
    .frm_err_o (frm),
    .overrun_o (ovr),
    .par_err_o (par)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int n_frm = 0, n_ovr = 0, n_par = 0, n_both = 0, n_vld = 0;
  int rise_cyc = 0, start_cyc = 0;
  logic vld_prev = 1'b0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (frm) n_frm++;
      if (ovr) n_ovr++;
      if (par) n_par++;
      if (frm && par) n_both++;
      if (bus.valid_o) n_vld++;
      if (bus.valid_o && !vld_prev) rise_cyc = cyc;
      vld_prev = bus.valid_o;
      if (bus.valid_o && bus.ready_i) begin
        chk("sb_nonempty", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("sb_data", bus.data_o, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(C);
  endtask

  task automatic clr_counts();
    n_frm = 0; n_ovr = 0; n_par = 0; n_both = 0; n_vld = 0;
  endtask

  // flip inverts the even-parity bit (only sent in parity builds)
  task automatic send(input logic [7:0] b, input logic stop, input logic flip);
    start_cyc = cyc + 1;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    if (PB != 0) drive_bit((^b) ^ flip);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  initial begin
    bus.ready_i = 1'b1;
    idle(3);
    chk("rst_data", bus.data_o, 8'h00);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_frm", frm, 1'b0);
    chk("rst_ovr", ovr, 1'b0);
    chk("rst_par", par, 1'b0);
    rst = 1'b0;
    idle(4);

    // Basic delivery with latency and single-cycle valid
    clr_counts();
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1, 1'b0);
    idle(2 * C);
    chk("a5_latency", rise_cyc - start_cyc, LAT);
    chk("a5_vld_cycles", n_vld, 1);
    chk("a5_flags", n_frm + n_ovr + n_par, 0);

    // Short glitch must be rejected and leave the receiver ready within 12 cycles
    clr_counts();
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(12);
    chk("glitch_vld", n_vld, 0);
    chk("glitch_flags", n_frm + n_ovr + n_par, 0);
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0);
    idle(2 * C);
    chk("post_glitch_latency", rise_cyc - start_cyc, LAT);

    // Framing error
    clr_counts();
    send(8'h3C, 1'b0, 1'b0);
    idle(3 * C);
    chk("frm_pulses", n_frm, 1);
    chk("frm_vld", n_vld, 0);
    chk("frm_ovr", n_ovr, 0);

    // Overrun while holding
    clr_counts();
    bus.ready_i = 1'b0;
    exp_q.push_back(8'h12);
    send(8'h12, 1'b1, 1'b0);
    idle(C);
    send(8'h34, 1'b1, 1'b0);
    idle(2 * C);
    chk("ovr_pulses", n_ovr, 1);
    chk("ovr_data", bus.data_o, 8'h12);
    chk("ovr_valid", bus.valid_o, 1'b1);
    bus.ready_i = 1'b1;
    idle(2);
    chk("ovr_valid_clr", bus.valid_o, 1'b0);

    // Reset in the middle of bit 4 of 0xFF
    clr_counts();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle(C / 2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(5 * C);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1, 1'b0);
    idle(2 * C);
    chk("rstmid_vld", n_vld, 1);
    chk("rstmid_flags", n_frm + n_ovr + n_par, 0);

    // Disable during the start bit aborts silently
    clr_counts();
    rx = 1'b0;
    idle(C / 2 + 4);
    en = 1'b0;
    idle(2);
    en = 1'b1;
    idle(C / 2 - 6);
    rx = 1'b1;
    idle(10 * C);
    chk("abort_vld", n_vld, 0);
    chk("abort_flags", n_frm + n_ovr + n_par, 0);

`ifdef TTHBIF_UART_RX_PARITY_EN
    clr_counts();
    send(8'h01, 1'b1, 1'b1);
    idle(2 * C);
    chk("par_pulses", n_par, 1);
    chk("par_vld", n_vld, 0);
    chk("par_frm", n_frm, 0);
    clr_counts();
    send(8'h01, 1'b0, 1'b1);
    idle(3 * C);
    chk("par_frm_both", n_both, 1);
    clr_counts();
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1, 1'b0);
    idle(2 * C);
    chk("par_good_vld", n_vld, 1);
    chk("par_good_flags", n_par + n_frm, 0);
`endif

    chk("sb_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
